// File: rtl/tune_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : tune_player_if
//  Description : Control, status and note-ROM signals of the background-music
//                sequencer. The master side is the game logic plus note ROM;
//                the slave side is the tune_player itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface tune_player_if #(
  parameter int AW    = 7,
  parameter int PER_W = 20,
  parameter int VOL_W = 3
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             loop_en;
  logic [AW-1:0]    last_idx;
  logic [1:0]       tempo;
  logic [VOL_W-1:0] volume;
  logic [AW-1:0]    note_addr;
  logic [PER_W-1:0] note_period;
  logic             beep;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step_idx;

  modport master (
    output start, stop, pause, loop_en, last_idx, tempo, volume, note_period,
    input  note_addr, beep, busy, done, step_idx
  );

  modport slave (
    input  start, stop, pause, loop_en, last_idx, tempo, volume, note_period,
    output note_addr, beep, busy, done, step_idx
  );
endinterface
`default_nettype wire

// File: rtl/tune_player.sv
`default_nettype none
// ============================================================================
//  Module      : tune_player
//  Description : Background-music sequencer. Walks a note table in an external
//                synchronous ROM and drives a square-wave tone on the buzzer
//                pin with runtime volume (duty) and tempo control, loop or
//                one-shot playback, and start/stop/pause.
//  Revision    : 1.0  initial release
// ============================================================================
module tune_player #(
  parameter int AW          = 7,
  parameter int PER_W       = 20,
  parameter int VOL_W       = 3,
  parameter int BEAT_W      = 26,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 0
) (
  input  wire logic    clk,
  input  wire logic    rst,
  tune_player_if.slave bus
);

  localparam logic [BEAT_W-1:0] c_BEAT_CYCLES = BEAT_W'(BEAT_CYCLES);
  localparam logic [BEAT_W-1:0] c_GAP_CYCLES  = BEAT_W'(GAP_CYCLES);
  localparam logic [BEAT_W-1:0] c_BEAT_ONE    = BEAT_W'(1);
  localparam logic [PER_W-1:0]  c_PER_ONE     = PER_W'(1);
  localparam logic [AW-1:0]     c_ADDR_ONE    = AW'(1);
  localparam int                c_PROD_W      = PER_W + VOL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_PLAY = 2'd3
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_note_addr;
  logic [AW-1:0]       r_step_idx;
  logic [PER_W-1:0]    r_cur_per;
  logic [PER_W-1:0]    r_tone_cnt;
  logic [BEAT_W-1:0]   r_beat_len;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic                r_beep;
  logic                r_busy;
  logic                r_done;

  logic [c_PROD_W-1:0] w_prod;
  logic [PER_W-1:0]    w_high_cyc;
  logic                w_beat_last;
  logic                w_audible;
  logic                w_tone_wrap;
  logic                w_tone_on;

  // Full-width product first so low periods keep their duty resolution; the
  // shift by VOL_W+1 caps the duty just below one half.
  assign w_prod      = {{VOL_W{1'b0}}, r_cur_per} * {{PER_W{1'b0}}, bus.volume};
  assign w_high_cyc  = {1'b0, w_prod[c_PROD_W-1:VOL_W+1]};

  // Step timing: last beat cycle and the articulation gap at the step tail.
  assign w_beat_last = (r_beat_cnt == (r_beat_len - c_BEAT_ONE));
  assign w_audible   = (r_beat_cnt < (r_beat_len - c_GAP_CYCLES));

  // A rest (period 0) holds the tone counter at zero.
  assign w_tone_wrap = (r_cur_per == '0) || (r_tone_cnt == (r_cur_per - c_PER_ONE));

  // Tone is high only in the first high_cyc cycles of each period.
  assign w_tone_on   = (r_state == S_PLAY) && !bus.pause && (r_cur_per != '0) &&
                       (r_tone_cnt < w_high_cyc) && w_audible;

  // Sequencer state, note/beat/tone counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_note_addr <= '0;
      r_step_idx  <= '0;
      r_cur_per   <= '0;
      r_tone_cnt  <= '0;
      r_beat_len  <= '0;
      r_beat_cnt  <= '0;
      r_beep      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_beep <= w_tone_on;
      if (bus.stop) begin
        // Abort wins over everything, including a simultaneous start.
        r_state     <= S_IDLE;
        r_note_addr <= '0;
        r_busy      <= 1'b0;
        r_beep      <= 1'b0;
      end else if (bus.start) begin
        // (Re)start from the first step, also when already playing.
        r_state     <= S_ADDR;
        r_note_addr <= '0;
        r_busy      <= 1'b1;
        r_beep      <= 1'b0;
      end else if (!bus.pause) begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_ADDR: begin
            // ROM registers note_addr during this cycle.
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            // ROM data is valid now: load the note and restart its phase.
            r_cur_per  <= bus.note_period;
            r_beat_len <= c_BEAT_CYCLES >> bus.tempo;
            r_step_idx <= r_note_addr;
            r_beat_cnt <= '0;
            r_tone_cnt <= '0;
            r_state    <= S_PLAY;
          end
          S_PLAY: begin
            if (w_beat_last) begin
              if (r_note_addr != bus.last_idx) begin
                r_note_addr <= r_note_addr + c_ADDR_ONE;
                r_state     <= S_ADDR;
              end else if (bus.loop_en) begin
                r_note_addr <= '0;
                r_state     <= S_ADDR;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
              r_tone_cnt <= w_tone_wrap ? '0 : (r_tone_cnt + c_PER_ONE);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.note_addr = r_note_addr;
  assign bus.step_idx  = r_step_idx;
  assign bus.beep      = r_beep;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tune_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tune_player
//  Description : Self-checking bench for tune_player. Two players (no gap and
//                a 4-cycle gap) share stimulus; a song-level model predicts
//                every output cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tune_player;

  localparam int AW     = 3;
  localparam int PER_W  = 8;
  localparam int VOL_W  = 3;
  localparam int BEAT_W = 26;
  localparam int BEAT   = 64;
  localparam int GAP1   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start    = 1'b0;
  logic             stop     = 1'b0;
  logic             pause    = 1'b0;
  logic             loop_en  = 1'b0;
  logic [AW-1:0]    last_idx = '0;
  logic [1:0]       tempo    = '0;
  logic [VOL_W-1:0] volume   = '0;
  logic [PER_W-1:0] rom [0:7];

  tune_player_if #(.AW(AW), .PER_W(PER_W), .VOL_W(VOL_W)) bus0 ();
  tune_player_if #(.AW(AW), .PER_W(PER_W), .VOL_W(VOL_W)) bus1 ();

  assign bus0.start = start;   assign bus1.start = start;
  assign bus0.stop = stop;     assign bus1.stop = stop;
  assign bus0.pause = pause;   assign bus1.pause = pause;
  assign bus0.loop_en = loop_en;   assign bus1.loop_en = loop_en;
  assign bus0.last_idx = last_idx; assign bus1.last_idx = last_idx;
  assign bus0.tempo = tempo;   assign bus1.tempo = tempo;
  assign bus0.volume = volume; assign bus1.volume = volume;

  // Synchronous note ROMs
  always @(posedge clk) begin
    bus0.note_period <= rom[bus0.note_addr];
    bus1.note_period <= rom[bus1.note_addr];
  end

  tune_player #(.AW(AW), .PER_W(PER_W), .VOL_W(VOL_W), .BEAT_W(BEAT_W),
                .BEAT_CYCLES(BEAT), .GAP_CYCLES(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  tune_player #(.AW(AW), .PER_W(PER_W), .VOL_W(VOL_W), .BEAT_W(BEAT_W),
                .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Song model: a queue holding what the player is doing after each clock
  // edge of an undisturbed run; pause re-emits the previous cycle silently.
  typedef struct {
    bit busy;
    bit done;
    bit play;
    int addr;
    int sidx;
    int j;
    int len;
    int per;
  } ent_t;

  ent_t q[$];
  int   qptr;
  ent_t prev;
  int   m_loop, m_last, m_t0, m_t1;

  function automatic bit would_beep(ent_t e, int gap, int vol);
    int hc;
    if (!e.play || e.per == 0) return 1'b0;
    hc = (e.per * vol) >> (VOL_W + 1);
    return ((e.j % e.per) < hc) && (e.j < e.len - gap);
  endfunction

  function automatic ent_t idle_ent(int addr, int sidx);
    ent_t e;
    e = '{default: 0};
    e.addr = addr;
    e.sidx = sidx;
    return e;
  endfunction

  task automatic build_song();
    ent_t e;
    int   nsteps, sidx, addr, len;
    q.delete();
    sidx   = prev.sidx;
    nsteps = (m_loop != 0) ? 3 * (m_last + 1) : m_last + 1;
    for (int k = 0; k < nsteps; k++) begin
      addr   = k % (m_last + 1);
      len    = BEAT >> ((k == 0) ? m_t0 : m_t1);
      e      = '{default: 0};
      e.busy = 1'b1;
      e.addr = addr;
      e.sidx = sidx;
      e.len  = len;
      e.per  = int'(rom[addr]);
      q.push_back(e);  // address phase
      q.push_back(e);  // ROM latency
      e.play = 1'b1;
      e.sidx = addr;
      for (int j = 0; j < len; j++) begin
        e.j = j;
        q.push_back(e);
      end
      sidx = addr;
    end
    if (m_loop == 0) begin
      e      = idle_ent(m_last, m_last);
      e.done = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic compare(ent_t cur, bit eb0, bit eb1);
    check_eq("beep_gap0", 32'(bus0.beep), 32'(eb0));
    check_eq("beep_gap4", 32'(bus1.beep), 32'(eb1));
    check_eq("busy0", 32'(bus0.busy), 32'(cur.busy));
    check_eq("busy1", 32'(bus1.busy), 32'(cur.busy));
    check_eq("done0", 32'(bus0.done), 32'(cur.done));
    check_eq("done1", 32'(bus1.done), 32'(cur.done));
    check_eq("note_addr0", 32'(bus0.note_addr), cur.addr);
    check_eq("note_addr1", 32'(bus1.note_addr), cur.addr);
    check_eq("step_idx0", 32'(bus0.step_idx), cur.sidx);
  endtask

  // One clock: drive controls, then predict and compare after the edge.
  task automatic tick(input bit st, input bit sp, input bit pa);
    ent_t cur;
    bit   eb0, eb1;
    eb0 = 1'b0;
    eb1 = 1'b0;
    @(negedge clk);
    start = st;
    stop  = sp;
    pause = pa;
    @(posedge clk);
    #1;
    if (sp) begin
      cur  = idle_ent(0, prev.sidx);
      q.delete();
      qptr = 0;
    end else if (st) begin
      build_song();
      cur  = q[0];
      qptr = 1;
    end else if (pa) begin
      cur      = prev;
      cur.done = 1'b0;
    end else begin
      eb0 = would_beep(prev, 0, int'(volume));
      eb1 = would_beep(prev, GAP1, int'(volume));
      if (qptr < q.size()) begin
        cur = q[qptr];
        qptr++;
      end else begin
        cur = idle_ent(prev.addr, prev.sidx);
      end
    end
    compare(cur, eb0, eb1);
    prev = cur;
  endtask

  // Start a song; tempo switches to t1 early in step 0, optional pause window.
  task automatic run_song(input int lp, input int last, input int t0, input int t1,
                          input int v, input int p_at, input int p_len,
                          input int n_cyc, input bit do_stop);
    int  n;
    bit  p;
    m_loop = lp; m_last = last; m_t0 = t0; m_t1 = t1;
    loop_en  = lp[0];
    last_idx = AW'(last);
    tempo    = 2'(t0);
    volume   = VOL_W'(v);
    tick(1'b1, 1'b0, 1'b0);
    if (n_cyc > 0)      n = n_cyc + p_len;
    else if (lp != 0)   n = int'($urandom_range(q.size() / 2, q.size() - 2)) + p_len;
    else                n = q.size() + p_len + 3;
    for (int c = 1; c <= n; c++) begin
      if (c == 6) tempo = 2'(t1);
      p = (p_len > 0) && (c >= p_at) && (c < p_at + p_len);
      tick(1'b0, 1'b0, p);
    end
    if (do_stop) tick(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int lp, last, pl;
    rom[0] = 8'd16;
    rom[1] = 8'd0;
    for (int i = 2; i < 8; i++)
      rom[i] = ($urandom % 4 == 0) ? 8'd0 : PER_W'($urandom_range(1, 40));
    prev = '{default: 0};
    qptr = 0;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare(prev, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Reference song: 16-cycle tone at volume 4, then a rest, one-shot
    run_song(0, 1, 0, 0, 4, 0, 0, 0, 1'b0);
    // Looping song for three passes, then stop
    run_song(1, 1, 0, 0, 4, 0, 0, 394, 1'b1);
    // Fast tempo with a tempo change inside step 0
    run_song(0, 1, 2, 0, 4, 0, 0, 0, 1'b0);
    // 50-cycle pause in the middle of step 0
    run_song(0, 1, 0, 0, 4, 20, 50, 0, 1'b0);
    // Muted
    run_song(0, 2, 0, 1, 0, 0, 0, 0, 1'b0);
    // Stop during PLAY, then simultaneous start and stop
    run_song(1, 1, 0, 0, 5, 0, 0, 40, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    // Start while busy restarts
    run_song(1, 2, 1, 1, 7, 0, 0, 30, 1'b0);
    run_song(0, 0, 3, 3, 6, 0, 0, 0, 1'b0);
    // Full address range in loop mode
    run_song(1, 7, 3, 3, 7, 0, 0, 0, 1'b1);

    // Randomized songs
    for (int r = 0; r < 16; r++) begin
      lp   = int'($urandom % 2);
      last = int'($urandom % 8);
      pl   = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 50));
      run_song(lp, last, int'($urandom % 4), int'($urandom % 4), int'($urandom % 8),
               int'($urandom_range(8, 60)), pl, 0, (lp != 0) && ($urandom % 3 != 0));
      repeat (int'($urandom % 4)) tick(1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of PLAY
    run_song(1, 3, 0, 0, 7, 0, 0, 20, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    prev = '{default: 0};
    q.delete();
    qptr = 0;
    compare(prev, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
